// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: repeat FSM encoding and timing defaults.
package btn_pkg;

    localparam int DEF_CHANNELS        = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_RATE     = 10000000;

    typedef logic [1:0] rpt_state_t;

    localparam rpt_state_t ST_IDLE   = 2'd0;
    localparam rpt_state_t ST_DELAY  = 2'd1;
    localparam rpt_state_t ST_REPEAT = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the conditioner and its user.
// release_p/event_p carry the release/event outputs; the plain names are SV keywords.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
);
    logic [CHANNELS-1:0] btn_raw;
    logic [CHANNELS-1:0] repeat_en;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] release_p;
    logic [CHANNELS-1:0] rpt;
    logic [CHANNELS-1:0] event_p;

    modport master (
        output btn_raw, repeat_en,
        input  level, press, release_p, rpt, event_p
    );

    modport slave (
        input  btn_raw, repeat_en,
        output level, press, release_p, rpt, event_p
    );
endinterface

// File: rtl/btn_chan.sv
// One button channel: two-flop synchroniser, debounce counter and auto-repeat FSM.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic i_arst_n,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_rpt,
    output logic o_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level, r_press, r_release, r_rpt, r_event;
    rpt_state_t    r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic          w_rpt_next;
    logic          w_differ, w_toggle, w_level_next, w_rise, w_fall;

    // The synchroniser leaves reset with the raw reset so the button is already
    // sampled by the time the rest of the channel comes out of reset.
    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differ     = r_sync2 ^ r_level;
    assign w_toggle     = w_differ && (r_cnt == CNT_LAST);
    assign w_level_next = r_level ^ w_toggle;
    assign w_rise       = w_toggle & ~r_level;
    assign w_fall       = w_toggle & r_level;

    // Leaving on the next level value keeps rpt off the cycle release asserts.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_rpt_next   = 1'b0;
        if (!w_level_next || !i_repeat_en) begin
            w_state_next = ST_IDLE;
            w_timer_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_DELAY;
                        w_timer_next = '0;
                    end
                end
                ST_DELAY: begin
                    if (r_timer == DELAY_LAST) begin
                        w_state_next = ST_REPEAT;
                        w_timer_next = '0;
                        w_rpt_next   = 1'b1;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_timer == RATE_LAST) begin
                        w_timer_next = '0;
                        w_rpt_next   = 1'b1;
                    end else begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
            r_event   <= 1'b0;
            r_state   <= ST_IDLE;
            r_timer   <= '0;
        end else begin
            r_cnt     <= (!w_differ || w_toggle) ? '0 : r_cnt + 1'b1;
            r_level   <= w_level_next;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_rpt     <= w_rpt_next;
            r_event   <= r_press | r_rpt;
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_rpt     = r_rpt;
    assign o_event   = r_event;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: debounced levels, edge pulses and auto-repeat.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic             Clk100M,
    input  logic             reset_n,
    btn_conditioner_if.slave bus
);
    logic                r_rst_meta, r_rst_sync;
    logic [CHANNELS-1:0] w_level, w_press, w_release, w_rpt, w_event;

    // Reset asserts immediately and releases two clocks later, clean to Clk100M.
    always_ff @(posedge Clk100M or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            btn_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_chan (
                .clk        (Clk100M),
                .i_arst_n   (reset_n),
                .i_rst_n    (r_rst_sync),
                .i_btn_raw  (bus.btn_raw[gi]),
                .i_repeat_en(bus.repeat_en[gi]),
                .o_level    (w_level[gi]),
                .o_press    (w_press[gi]),
                .o_release  (w_release[gi]),
                .o_rpt      (w_rpt[gi]),
                .o_event    (w_event[gi])
            );
        end
    endgenerate

    assign bus.level     = w_level;
    assign bus.press     = w_press;
    assign bus.release_p = w_release;
    assign bus.rpt       = w_rpt;
    assign bus.event_p   = w_event;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with 2 channels, debounce 4, repeat delay 10, rate 3.
module tb_btn_conditioner;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    btn_conditioner_if #(.CHANNELS(CH)) bus();

    btn_conditioner #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3)
    ) dut (
        .Clk100M(clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Output snapshot order: {level, press, release, rpt, event}, 2 bits each.
    function automatic logic [9:0] pack(input logic [1:0] l, input logic [1:0] p,
                                        input logic [1:0] r, input logic [1:0] t,
                                        input logic [1:0] e);
        return {l, p, r, t, e};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.level, bus.press, bus.release_p, bus.rpt, bus.event_p};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end else begin
            $display("ok   %s got=%b", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic hit, ev;
        reset_n       = 1'b0;
        bus.btn_raw   = '0;
        bus.repeat_en = '0;

        step(3);
        check("reset_hold", observed(), 10'b0);
        reset_n = 1'b1;
        step(6);
        check("after_reset_idle", observed(), 10'b0);

        // Clean press then release on ch0, no repeat.
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("press k=%0d", k), observed(),
                  pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, {1'b0, k == 7}));
        end
        bus.btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("release k=%0d", k), observed(),
                  pack({1'b0, k < 6}, 2'b00, {1'b0, k == 6}, 2'b00, 2'b00));
        end

        // 3-cycle glitch on ch1 must be ignored.
        bus.btn_raw = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("glitch k=%0d", k), observed(), 10'b0);
            if (k == 3) bus.btn_raw = 2'b00;
        end

        // ch0 held 30 cycles with auto-repeat.
        bus.repeat_en = 2'b01;
        bus.btn_raw   = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            hit = (k >= 16) && (k <= 34) && ((k - 16) % 3 == 0);
            ev  = (k == 7) || ((k >= 17) && (k <= 35) && ((k - 17) % 3 == 0));
            check($sformatf("hold k=%0d", k), observed(),
                  pack({1'b0, (k >= 6) && (k < 36)}, {1'b0, k == 6}, {1'b0, k == 36},
                       {1'b0, hit}, {1'b0, ev}));
            if (k == 30) bus.btn_raw = 2'b00;
        end
        bus.repeat_en = 2'b00;

        // Both channels pressed together.
        bus.btn_raw = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            check($sformatf("both_press k=%0d", k), observed(),
                  pack({2{k >= 6}}, {2{k == 6}}, 2'b00, 2'b00, {2{k == 7}}));
        end
        bus.btn_raw = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check($sformatf("both_release k=%0d", k), observed(),
                  pack({2{k < 6}}, 2'b00, {2{k == 6}}, 2'b00, 2'b00));
        end

        // repeat_en dropped in REPEAT; re-enabling must not restart repeats.
        bus.repeat_en = 2'b01;
        bus.btn_raw   = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            check($sformatf("en_drop k=%0d", k), observed(),
                  pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k == 16},
                       {1'b0, (k == 7) || (k == 17)}));
            if (k == 17) bus.repeat_en = 2'b00;
            if (k == 20) bus.repeat_en = 2'b01;
        end
        bus.btn_raw   = 2'b00;
        bus.repeat_en = 2'b00;
        step(8);
        check("en_drop_released", observed(), 10'b0);

        // Reset pulse during REPEAT with the button still held.
        bus.repeat_en = 2'b01;
        bus.btn_raw   = 2'b01;
        step(19);
        check("pre_reset_rpt", observed(), pack(2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
        step(1);
        reset_n = 1'b0;
        #1;
        check("reset_immediate", observed(), 10'b0);
        step(2);
        check("reset_held", observed(), 10'b0);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("post_reset k=%0d", k), observed(),
                  pack({1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, {1'b0, k == 7}));
        end
        bus.btn_raw   = 2'b00;
        bus.repeat_en = 2'b00;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
